seq_mult_8bit: RTL and testbench

SEQ_MULT_8BIT -- requirements
Module: seq_mult_8bit

---
 rtl/seq_mult_8bit_if.sv | 12 +
 rtl/Adder_8bit.sv | 9 +
 rtl/seq_mult_8bit.sv | 111 +++++++++++
 tb/tb_seq_mult_8bit.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/seq_mult_8bit_if.sv
// Operand/result bundle for the sequential 8x8 multiplier.
interface seq_mult_8bit_if;
    logic        start;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [15:0] Product;
    logic        busy;
    logic        done;

    modport master (output start, A, B, input Product, busy, done);
    modport slave  (input start, A, B, output Product, busy, done);
endinterface

// File: rtl/Adder_8bit.sv
// 8-bit unsigned adder; the multiplier's only adder.
module Adder_8bit (
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [7:0] Sum,
    output logic       CarryOut
);
    assign {CarryOut, Sum} = 9'(A) + 9'(B);
endmodule

// File: rtl/seq_mult_8bit.sv
// Shift-and-add 8x8 unsigned multiplier: 8 CALC cycles, one DONE cycle, one shared adder.
module seq_mult_8bit (
    input  logic           clk,
    input  logic           rst_n,
    seq_mult_8bit_if.slave bus
);
    localparam int unsigned W  = 8;
    localparam int unsigned PW = 16;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    mcand_q, mcand_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   product_q, product_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [W-1:0]    sum;
    logic            carry;
    logic [W:0]      acc;

    Adder_8bit u_add (
        .A        (hi_q),
        .B        (mcand_q),
        .Sum      (sum),
        .CarryOut (carry)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            count_q   <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            count_q   <= count_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        count_d   = count_q;
        product_d = product_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        acc       = {1'b0, hi_q};

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CALC;
                    mcand_d = bus.A;
                    lo_d    = bus.B;
                    hi_d    = '0;
                    count_d = '0;
                    busy_d  = 1'b1;
                end
            end
            CALC: begin
                // Conditional add of the multiplicand, then shift {carry,hi,lo} right one
                if (lo_q[0]) begin
                    acc = {carry, sum};
                end
                hi_d    = acc[W:1];
                lo_d    = {acc[0], lo_q[W-1:1]};
                count_d = count_q + CW'(1);
                if (count_q == CW'(W - 1)) begin
                    state_d   = DONE;
                    product_d = {hi_d, lo_d};
                    done_d    = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.Product = product_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_seq_mult_8bit.sv
// Scoreboard bench for seq_mult_8bit: expected A*B queued at accept, checked at each done.
module tb_seq_mult_8bit;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    seq_mult_8bit_if bus ();

    seq_mult_8bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned done_count = 0;
    logic [15:0] exp_q[$];
    logic        busy_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Advance to the next sampling point; a rising busy marks an accept of the operands on the bus
    task automatic tick();
        @(negedge clk);
        if (rst_n && bus.busy === 1'b1 && !busy_prev)
            exp_q.push_back(16'(bus.A) * 16'(bus.B));
        busy_prev = rst_n ? bus.busy : 1'b0;
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b);
        logic seen;
        seen = 1'b0;
        bus.A = a;
        bus.B = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            bus.A = 8'($urandom);
            bus.B = 8'($urandom);
            tick();
            seen = (bus.done === 1'b1);
        end
        chk("done_arrived", 32'(seen), 32'(1));
        tick();
    endtask

    // Monitor: result scoreboard, pulse shape, latency, exclusivity, product hold
    initial begin : monitor
        logic        done_prev;
        int unsigned busy_run;
        logic [15:0] last_prod;
        logic [15:0] e;
        done_prev = 1'b0;
        busy_run  = 0;
        last_prod = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                done_prev = 1'b0;
                busy_run  = 0;
                last_prod = '0;
            end else begin
                chk("busy_done_excl", 32'(bus.busy & bus.done), 32'(0));
                if (bus.done === 1'b1) begin
                    done_count++;
                    chk("done_width", 32'(done_prev), 32'(0));
                    chk("calc_cycles", busy_run, 32'(8));
                    chk("done_has_expect", 32'(exp_q.size() != 0), 32'(1));
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("product", 32'(bus.Product), 32'(e));
                        last_prod = e;
                    end
                    busy_run = 0;
                end else begin
                    chk("product_hold", 32'(bus.Product), 32'(last_prod));
                    if (bus.busy === 1'b1) busy_run++;
                end
                done_prev = bus.done;
            end
        end
    end

    initial begin : stimulus
        int unsigned dc;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        #1;
        chk("reset_product", 32'(bus.Product), 32'(0));
        chk("reset_busy", 32'(bus.busy), 32'(0));
        chk("reset_done", 32'(bus.done), 32'(0));
        repeat (3) tick();
        rst_n = 1'b1;

        // Directed corner operands
        run_op(8'hCA, 8'h67);
        run_op(8'hFF, 8'hFF);
        run_op(8'h80, 8'h01);
        run_op(8'h00, 8'hB7);
        run_op(8'hB7, 8'h00);
        run_op(8'h01, 8'hFF);

        // start held high with operands churning every cycle
        dc = done_count;
        bus.A = 8'($urandom);
        bus.B = 8'($urandom);
        bus.start = 1'b1;
        repeat (60) begin
            tick();
            bus.A = 8'($urandom);
            bus.B = 8'($urandom);
        end
        bus.start = 1'b0;
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
        chk("held_start_drain", 32'(exp_q.size()), 32'(0));
        chk("held_start_runs", 32'(done_count - dc >= 5), 32'(1));
        repeat (2) tick();

        // Reset in the middle of CALC
        bus.A = 8'hE3;
        bus.B = 8'h5D;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_product", 32'(bus.Product), 32'(0));
        chk("midrst_busy", 32'(bus.busy), 32'(0));
        chk("midrst_done", 32'(bus.done), 32'(0));
        exp_q.delete();
        dc = done_count;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (12) tick();
        chk("midrst_no_done", done_count, dc);
        run_op(8'h11, 8'h0F);

        // Random operand pairs
        repeat (2000) run_op(8'($urandom), 8'($urandom));

        repeat (3) tick();
        chk("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
